// File: rtl/gf16mul_arb.sv
// gf16mul_arb: round-robin arbiter sharing one GF(16) multiplier (x^4+x+1)
// between NREQ requesters, with one registered response stage that carries
// the product and the requester ID and honours backpressure.
//
// Build option: define GF16_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins, pointer held at 0). Default is round-robin.

// Combinational GF(16) multiplier, field polynomial x^4+x+1.
module gf16mul_dec (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [3:0] z_o
);
    logic [3:0] acc;
    logic [3:0] sh;

    // Shift-and-add: sh walks a*x^i reduced mod x^4+x+1, acc sums the terms selected by b.
    always_comb begin
        acc = 4'd0;
        sh  = a_i;
        for (int i = 0; i < 4; i++) begin
            if (b_i[i]) begin
                acc = acc ^ sh;
            end
            sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'b0011 : 4'b0000);
        end
        z_o = acc;
    end
endmodule

module gf16mul_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [3:0]        rsp_z,
    output logic [IDW-1:0]    rsp_id
);
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [3:0]     rsp_z_q, rsp_z_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;

    logic           found;
    logic [IDW-1:0] g;
    int             scan_idx;
    logic           free;
    logic           xfer;
    logic [3:0]     op_a, op_b, prod;

    // Circular scan of req_valid from ptr; first set bit is the grant.
    always_comb begin
        found    = 1'b0;
        g        = '0;
        scan_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!found && req_valid[scan_idx]) begin
                found = 1'b1;
                g     = IDW'(scan_idx);
            end
        end
    end

    // Operand mux from the granted requester.
    always_comb begin
        op_a = 4'd0;
        op_b = 4'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (g == IDW'(i)) begin
                op_a = req_a[4*i +: 4];
                op_b = req_b[4*i +: 4];
            end
        end
    end

    gf16mul_dec u_mul (
        .a_i (op_a),
        .b_i (op_b),
        .z_o (prod)
    );

    // Handshake: the stage is free when empty or being popped; rst_n gates ready so nothing is accepted in reset.
    always_comb begin
        free      = ~rsp_valid_q | rsp_ready;
        xfer      = found & free & rst_n;
        req_ready = xfer ? (NREQ'(1) << g) : '0;
    end

    // Next state of the response stage and the round-robin pointer.
    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_z_d     = rsp_z_q;
        rsp_id_d    = rsp_id_q;
        if (xfer) begin
            rsp_valid_d = 1'b1;
            rsp_z_d     = prod;
            rsp_id_d    = g;
`ifdef GF16_ARB_FIXED_PRIO_EN
            ptr_d       = '0;
`else
            ptr_d       = (g == IDW'(NREQ-1)) ? '0 : g + IDW'(1);
`endif
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_z_q     <= 4'd0;
            rsp_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_z_q     <= rsp_z_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_gf16mul_arb.sv
// Testbench for gf16mul_arb: directed steps followed by a random phase, all
// checked against a behavioural model (integer GF(16) multiply by polynomial
// long division, integer round-robin pointer).
module tb_gf16mul_arb;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [3:0]        rsp_z;
    logic [IDW-1:0]    rsp_id;

    int n_cmp = 0;
    int n_err = 0;

    int m_valid, m_z, m_id, m_ptr;
    logic [NREQ-1:0] m_acc;

    always #5 clk = ~clk;

    gf16mul_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_id    (rsp_id)
    );

    function automatic int gmul(int a, int b);
        int p = 0;
        for (int i = 0; i < 4; i++)
            if ((b >> i) & 1) p = p ^ (a << i);
        for (int d = 6; d >= 4; d--)
            if ((p >> d) & 1) p = p ^ ('h13 << (d - 4));
        return p;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setreq(int i, int a, int b);
        req_valid[i]     = 1'b1;
        req_a[4*i +: 4]  = 4'(a);
        req_b[4*i +: 4]  = 4'(b);
    endtask

    // One clock: check ready against the model, advance model at the edge,
    // check the response stage, retire accepted requests.
    task automatic cycle(string tag);
        int g = -1;
        int idx;
        bit free;
        logic [NREQ-1:0] er;
        #1;
        free = (m_valid == 0) || rsp_ready;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        er = '0;
        if (rst_n && free && g >= 0) er[g] = 1'b1;
        chk({tag, ".ready"}, 32'(req_ready), 32'(er));
        @(posedge clk);
        m_acc = er;
        if (!rst_n) begin
            m_valid = 0; m_z = 0; m_id = 0; m_ptr = 0;
        end else if (er != '0) begin
            m_valid = 1;
            m_z     = gmul(int'(req_a[4*g +: 4]), int'(req_b[4*g +: 4]));
            m_id    = g;
`ifndef GF16_ARB_FIXED_PRIO_EN
            m_ptr   = (g + 1) % NREQ;
`endif
        end else if (rsp_ready) begin
            m_valid = 0;
        end
        #1;
        chk({tag, ".valid"}, 32'(rsp_valid), 32'(m_valid));
        chk({tag, ".z"},     32'(rsp_z),     32'(m_z));
        chk({tag, ".id"},    32'(rsp_id),    32'(m_id));
        for (int i = 0; i < NREQ; i++)
            if (m_acc[i]) req_valid[i] = 1'b0;
    endtask

    initial begin
        int pa[5] = '{7, 15, 0, 11, 5};
        int pb[5] = '{7, 15, 13, 0, 1};
        int pz[5] = '{6, 10, 0, 0, 5};
        m_valid = 0; m_z = 0; m_id = 0; m_ptr = 0; m_acc = '0;
        rst_n = 1'b0; rsp_ready = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0;
        @(posedge clk); #1;
        m_valid = 0; m_z = 0; m_id = 0; m_ptr = 0;

        // Reset with all inputs active
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < NREQ; i++) setreq(i, i + 3, i + 5);
            cycle("reset");
            chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        end

        // Single request after release
        rst_n = 1'b1;
        req_valid = '0;
        setreq(1, 9, 2);
        cycle("single");
        chk("single.z_const",  32'(rsp_z),  32'd1);
        chk("single.id_const", 32'(rsp_id), 32'd1);

        // Product checks from requester 0
        for (int i = 0; i < 5; i++) begin
            setreq(0, pa[i], pb[i]);
            cycle("prod");
            chk("prod.z_const", 32'(rsp_z), 32'(pz[i]));
        end

        // Move pointer to 0 via requester 3, then rotation with all valid
        setreq(3, 1, 1);
        cycle("pre_rot");
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i]) setreq(i, $urandom_range(0, 15), $urandom_range(0, 15));
            cycle("rot");
`ifdef GF16_ARB_FIXED_PRIO_EN
            chk("rot.id_seq", 32'(rsp_id), 32'd0);
`else
            chk("rot.id_seq", 32'(rsp_id), 32'(k % NREQ));
`endif
        end
        req_valid = '0;
        cycle("drain");

        // Backpressure holding 3*4 from requester 2
        setreq(2, 3, 4);
        cycle("bp_load");
        chk("bp_load.z_const", 32'(rsp_z), 32'd12);
        rsp_ready = 1'b0;
        setreq(0, 5, 6);
        for (int c = 0; c < 3; c++) begin
            cycle("bp_hold");
            chk("bp_hold.z_const",  32'(rsp_z),     32'd12);
            chk("bp_hold.id_const", 32'(rsp_id),    32'd2);
            chk("bp_hold.ready0",   32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        cycle("bp_release");
        chk("bp_release.valid", 32'(rsp_valid), 32'd1);
        chk("bp_release.id",    32'(rsp_id),    32'd0);
        chk("bp_release.z",     32'(rsp_z),     32'd13);

        // Wrap and idle
        setreq(3, 2, 3);
        cycle("wrap3");
        chk("wrap3.id", 32'(rsp_id), 32'd3);
        cycle("idle");
        cycle("idle");
        chk("idle.valid", 32'(rsp_valid), 32'd0);
        setreq(0, 4, 4);
        setreq(3, 8, 8);
        cycle("wrap_first");
        chk("wrap_first.id", 32'(rsp_id), 32'd0);
        cycle("wrap_second");
        chk("wrap_second.id", 32'(rsp_id), 32'd3);

        // Reset while the stage holds a response
        setreq(1, 6, 7);
        cycle("pre_rst");
        rsp_ready = 1'b0;
        setreq(1, 6, 7);
        setreq(3, 9, 9);
        rst_n = 1'b0;
        cycle("mid_rst");
        chk("mid_rst.valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst.id",    32'(rsp_id),    32'd0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        cycle("post_rst");
        chk("post_rst.id", 32'(rsp_id), 32'd1);

        // Random phase
        for (int c = 0; c < 400; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 63) != 0);
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    setreq(i, $urandom_range(0, 15), $urandom_range(0, 15));
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
